shiftrows_colfeed: RTL

- Upstream neighbour of the single-column MixColumns unit (32-bit column in, registered 32-bit column out, 1-cycle latency, no handshake).
- Accepts one 128-bit AES state per transaction over valid/ready, applies ShiftRows, and streams the four resulting columns, column 0 first, one per beat over valid/ready.
- Each beat carries a column index, a last flag and a final-round tag, so downstream logic can align or bypass the MixColumns result.

---
 rtl/aes_pkg.sv | 39 +++
 rtl/shiftrows_colfeed.sv | 86 ++++++++
 2 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and the ShiftRows byte permutation (pure wiring), reused by the column feeder
// and by any future full-round datapath.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  column_t;
  typedef logic [7:0]   byte_t;
  typedef logic [1:0]   col_idx_t;

  localparam int NUM_COLS = 4;

  // Byte k sits at bits [127-8k -: 8]; s[r][c] is byte 4c+r.
  function automatic state_t shift_rows(input state_t s, input bit inv);
    state_t o;
    byte_t  b;
    int     src;
    o = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? ((c - r + NUM_COLS) % NUM_COLS) : ((c + r) % NUM_COLS);
        b   = s[127 - 8*(4*src + r) -: 8];
        o[127 - 8*(4*c + r) -: 8] = b;
      end
    end
    return o;
  endfunction

  function automatic column_t get_column(input state_t s, input col_idx_t c);
    column_t col;
    case (c)
      2'd0:    col = s[127:96];
      2'd1:    col = s[95:64];
      2'd2:    col = s[63:32];
      default: col = s[31:0];
    endcase
    return col;
  endfunction

endpackage

// File: rtl/shiftrows_colfeed.sv
// Accepts a 128-bit state, applies (Inv)ShiftRows (SHIFTROWS_INV_EN adds i_inv/o_inv) and streams 4 columns,
// first column 1 cycle after acceptance; columns hold under i_ready low, next state accepted on the last beat.
module shiftrows_colfeed
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] i_state,
  input  logic         i_final,
`ifdef SHIFTROWS_INV_EN
  input  logic         i_inv,
  output logic         o_inv,
`endif
  input  logic         i_valid,
  output logic         o_ready,
  output logic [31:0]  o_column,
  output logic [1:0]   o_col_idx,
  output logic         o_last,
  output logic         o_final,
  output logic         o_valid,
  input  logic         i_ready
);

  typedef enum logic {IDLE, SEND} fsm_t;

  fsm_t     r_fsm;
  state_t   r_state;
  col_idx_t r_col_idx;
  logic     r_final;

  logic     w_inv;
  state_t   w_shifted;
  logic     w_last;
  logic     w_accept;
  logic     w_beat;

`ifdef SHIFTROWS_INV_EN
  logic     r_inv;
  assign w_inv = i_inv;
  assign o_inv = r_inv;
`else
  assign w_inv = 1'b0;
`endif

  assign w_shifted = shift_rows(i_state, w_inv);

  assign o_valid   = (r_fsm == SEND);
  assign w_last    = o_valid & (r_col_idx == 2'd3);
  assign w_beat    = o_valid & i_ready;
  // Ready on the final beat lets a new state follow with no bubble.
  assign o_ready   = (r_fsm == IDLE) | (w_last & i_ready);
  assign w_accept  = i_valid & o_ready;

  assign o_column  = get_column(r_state, r_col_idx);
  assign o_col_idx = r_col_idx;
  assign o_last    = w_last;
  assign o_final   = r_final;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fsm     <= IDLE;
      r_state   <= '0;
      r_col_idx <= '0;
      r_final   <= 1'b0;
`ifdef SHIFTROWS_INV_EN
      r_inv     <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_state   <= w_shifted;
        r_final   <= i_final;
`ifdef SHIFTROWS_INV_EN
        r_inv     <= w_inv;
`endif
        r_col_idx <= '0;
        r_fsm     <= SEND;
      end else if (w_beat) begin
        if (w_last)
          r_fsm <= IDLE;
        else
          r_col_idx <= r_col_idx + 2'd1;
      end
    end
  end

endmodule
